ex_muldiv_stage: RTL and testbench

Parametrised execute stage and EX/MEM pipeline register with an integrated multiply/divide unit. It selects each operand from the register file or one of `NFWD` forwarding sources, applies the PC/immediate operand overrides and computes the result. Single-cycle ALU and multiply results are captured into the MEM-side register. Divide/remainder ops run on an iterative divider that stalls the front end until the result is ready. The stage also supports flush and downstream back-pressure.

---
 rtl/ex_muldiv_stage.sv | 194 +++++++++++++++++++
 tb/tb_ex_muldiv_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage.sv
// Execute stage with forwarding muxes, single-cycle ALU/multiplier, an iterative
// restoring divider and the EX/MEM pipeline register.
module ex_muldiv_stage #(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    localparam int SELW = $clog2(NFWD + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [4:0]           op,
    input  logic [SELW-1:0]      src1_sel,
    input  logic [SELW-1:0]      src2_sel,
    input  logic                 use_pc,
    input  logic                 use_imm,
    input  logic [XLEN-1:0]      pc_ex,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [4:0]           rd_addr_ex,
    input  logic                 wb_en_ex,
    input  logic                 flush,
    input  logic                 mem_stall,
    output logic                 ex_stall,
    output logic [XLEN-1:0]      store_data_ex,
    output logic [XLEN-1:0]      alu_out_wire,
    output logic                 out_valid,
    output logic                 wb_en_mem,
    output logic [4:0]           rd_addr_mem,
    output logic [XLEN-1:0]      alu_out_mem
);
    localparam int SHW  = $clog2(XLEN);
    localparam int NSEL = 1 << SELW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    // Select codes above NFWD fall back to the register-file value.
    logic [XLEN-1:0] src1_tbl [NSEL];
    logic [XLEN-1:0] src2_tbl [NSEL];
    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_src
            if (gi >= 1 && gi <= NFWD) begin : g_fwd
                assign src1_tbl[gi] = fwd_data[(gi-1)*XLEN +: XLEN];
                assign src2_tbl[gi] = fwd_data[(gi-1)*XLEN +: XLEN];
            end else begin : g_reg
                assign src1_tbl[gi] = rs1_data;
                assign src2_tbl[gi] = rs2_data;
            end
        end
    endgenerate

    logic [XLEN-1:0] src1_val, src2_val, op_a, op_b;
    logic [SHW-1:0]  shamt;

    assign src1_val      = src1_tbl[src1_sel];
    assign src2_val      = src2_tbl[src2_sel];
    assign op_a          = use_pc  ? pc_ex : src1_val;
    assign op_b          = use_imm ? imm   : src2_val;
    assign store_data_ex = src2_val;
    assign shamt         = op_b[SHW-1:0];

    logic [XLEN-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (op[3:0])
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // One 2*XLEN multiplier; signedness is applied through operand extension.
    logic              mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [XLEN-1:0]   mul_res;

    assign mul_a_sgn = (op[1:0] == 2'd1) || (op[1:0] == 2'd2);
    assign mul_b_sgn = (op[1:0] == 2'd1);
    assign mul_a     = {{XLEN{mul_a_sgn & op_a[XLEN-1]}}, op_a};
    assign mul_b     = {{XLEN{mul_b_sgn & op_b[XLEN-1]}}, op_b};
    assign mul_p     = mul_a * mul_b;
    assign mul_res   = (op[1:0] == 2'd0) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

    logic is_div_op, div_req;
    assign is_div_op    = op[4] & op[2];
    assign div_req      = in_valid & is_div_op;
    assign alu_out_wire = !op[4] ? alu_res : (op[2] ? '0 : mul_res);

    div_state_t      state_q;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvsr_q;
    logic            q_neg_q, r_neg_q, div_zero_q, rem_op_q;

    logic            div_signed, a_neg, b_neg;
    logic [XLEN:0]   rem_shift, rem_diff;
    logic [XLEN-1:0] q_fix, r_fix, div_res;

    assign div_signed = ~op[0];
    assign a_neg      = div_signed & op_a[XLEN-1];
    assign b_neg      = div_signed & op_b[XLEN-1];
    assign rem_shift  = {rem_q, quo_q[XLEN-1]};
    assign rem_diff   = rem_shift - {1'b0, dvsr_q};

    // Divisor-zero and MIN/-1 fall out of the magnitude datapath, except the
    // signed divide-by-zero quotient which must be forced to all ones.
    assign q_fix   = q_neg_q ? -quo_q : quo_q;
    assign r_fix   = r_neg_q ? -rem_q : rem_q;
    assign div_res = rem_op_q ? r_fix : (div_zero_q ? '1 : q_fix);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            rem_op_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_req) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        quo_q      <= a_neg ? -op_a : op_a;
                        dvsr_q     <= b_neg ? -op_b : op_b;
                        rem_q      <= '0;
                        q_neg_q    <= a_neg ^ b_neg;
                        r_neg_q    <= a_neg;
                        div_zero_q <= (op_b == '0);
                        rem_op_q   <= op[1];
                    end
                end
                RUN: begin
                    if (!rem_diff[XLEN]) begin
                        rem_q <= rem_diff[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SHW'(XLEN - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!mem_stall) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_stall = ~flush & (mem_stall | (div_req & (state_q != DONE)));

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            out_valid   <= 1'b0;
            wb_en_mem   <= 1'b0;
            rd_addr_mem <= '0;
            alu_out_mem <= '0;
        end else if (mem_stall) begin
            out_valid   <= out_valid;
        end else if ((div_req && state_q != DONE) || !in_valid) begin
            out_valid   <= 1'b0;
            wb_en_mem   <= 1'b0;
            rd_addr_mem <= '0;
            alu_out_mem <= '0;
        end else begin
            out_valid   <= 1'b1;
            wb_en_mem   <= wb_en_ex;
            rd_addr_mem <= rd_addr_ex;
            alu_out_mem <= (state_q == DONE) ? div_res : alu_out_wire;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage: stimulus pushes model results, a monitor
// pops them whenever the MEM register captures a valid instruction.
module tb_ex_muldiv_stage;
    localparam int XLEN = 32;
    localparam int NFWD = 2;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic [4:0]      op = '0;
    logic [SELW-1:0] src1_sel = '0, src2_sel = '0;
    logic            use_pc = 1'b0, use_imm = 1'b0;
    logic [XLEN-1:0] pc_ex = '0, imm = '0, rs1_data = '0, rs2_data = '0;
    logic [NFWD*XLEN-1:0] fwd_data = '0;
    logic [4:0]      rd_addr_ex = '0;
    logic            wb_en_ex = 1'b0, flush = 1'b0, mem_stall = 1'b0;
    logic            ex_stall, out_valid, wb_en_mem;
    logic [XLEN-1:0] store_data_ex, alu_out_wire, alu_out_mem;
    logic [4:0]      rd_addr_mem;

    always #5 clk = ~clk;

    ex_muldiv_stage #(.XLEN(XLEN), .NFWD(NFWD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op),
        .src1_sel(src1_sel), .src2_sel(src2_sel), .use_pc(use_pc), .use_imm(use_imm),
        .pc_ex(pc_ex), .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_data(fwd_data), .rd_addr_ex(rd_addr_ex), .wb_en_ex(wb_en_ex),
        .flush(flush), .mem_stall(mem_stall), .ex_stall(ex_stall),
        .store_data_ex(store_data_ex), .alu_out_wire(alu_out_wire),
        .out_valid(out_valid), .wb_en_mem(wb_en_mem), .rd_addr_mem(rd_addr_mem),
        .alu_out_mem(alu_out_mem)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] r1, r2, pc, imm;
        logic [63:0] fwd;
        logic [1:0]  s1, s2;
        logic        upc, uimm;
        logic [4:0]  rd;
        logic        wb;
    } instr_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wb;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    // Reference: RISC-V style semantics written with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        int              sh;
        logic [31:0]     r;
        sa = $signed(a); sb = $signed(b);
        ua = {32'b0, a}; ub = {32'b0, b};
        sh = int'(b % 32);
        r  = '0;
        if (!o[4]) begin
            case (o[3:0])
                4'd0:  r = a + b;
                4'd1:  r = a - b;
                4'd2:  r = a << sh;
                4'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
                4'd4:  r = (ua < ub) ? 32'd1 : 32'd0;
                4'd5:  r = a ^ b;
                4'd6:  r = a >> sh;
                4'd7:  begin p = sa >>> sh; r = p[31:0]; end
                4'd8:  r = a | b;
                4'd9:  r = a & b;
                4'd10: r = b;
                default: r = '0;
            endcase
        end else begin
            case (o[2:0])
                3'd0: begin p = sa * sb; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
                3'd3: begin pu = ua * ub; r = pu[63:32]; end
                3'd4: begin
                    if (b == 0) r = 32'hFFFFFFFF;
                    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                    else begin p = sa / sb; r = p[31:0]; end
                end
                3'd5: begin
                    if (b == 0) r = 32'hFFFFFFFF;
                    else begin pu = ua / ub; r = pu[31:0]; end
                end
                3'd6: begin
                    if (b == 0) r = a;
                    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                    else begin p = sa % sb; r = p[31:0]; end
                end
                default: begin
                    if (b == 0) r = a;
                    else begin pu = ua % ub; r = pu[31:0]; end
                end
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [63:0] f, input logic [31:0] r);
        if (s == 2'd1) return f[31:0];
        if (s == 2'd2) return f[63:32];
        return r;
    endfunction

    function automatic instr_t plain(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        instr_t in;
        in.op = o; in.r1 = a; in.r2 = b; in.pc = '0; in.imm = '0; in.fwd = '0;
        in.s1 = 2'd0; in.s2 = 2'd0; in.upc = 1'b0; in.uimm = 1'b0;
        in.rd = 5'($urandom_range(1, 31)); in.wb = 1'b1;
        return in;
    endfunction

    task automatic drive(input instr_t in);
        op = in.op; rs1_data = in.r1; rs2_data = in.r2; pc_ex = in.pc; imm = in.imm;
        fwd_data = in.fwd; src1_sel = in.s1; src2_sel = in.s2; use_pc = in.upc;
        use_imm = in.uimm; rd_addr_ex = in.rd; wb_en_ex = in.wb; in_valid = 1'b1; flush = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    endtask

    // Issues one instruction and holds it until EX releases it.
    task automatic issue(input instr_t in, input int hold, input bit rnd_stall,
                         input bit scramble, output int stalls);
        logic [31:0] a, bsrc, b, res;
        logic        isdiv;
        bit          done;
        exp_t        e;
        a     = in.upc ? in.pc : pick(in.s1, in.fwd, in.r1);
        bsrc  = pick(in.s2, in.fwd, in.r2);
        b     = in.uimm ? in.imm : bsrc;
        res   = model(in.op, a, b);
        isdiv = in.op[4] & in.op[2];
        e.res = res; e.rd = in.rd; e.wb = in.wb;
        exp_q.push_back(e);
        stalls = 0;
        done   = 0;
        @(posedge clk); #1;
        drive(in);
        for (int c = 0; c < 300; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (hold > 0) mem_stall = (c >= XLEN + 1) && (c < XLEN + 1 + hold);
            else          mem_stall = rnd_stall && ($urandom_range(0, 3) == 0);
            if (scramble && c > 0) begin
                rs1_data = $urandom; rs2_data = $urandom; pc_ex = $urandom; imm = $urandom;
                fwd_data = {$urandom, $urandom};
            end
            @(negedge clk);
            if (c == 0) begin
                chk("store_data_ex", store_data_ex, bsrc);
                chk("alu_out_wire", alu_out_wire, isdiv ? 32'd0 : res);
            end
            if (!ex_stall) begin done = 1; break; end
            stalls++;
        end
        if (!done) begin
            n_total++;
            $display("FAIL issue_timeout: ex_stall still 1 after 300 cycles, required 0");
        end
    endtask

    // Directed op: result checked against a hand-derived constant and stall length.
    task automatic run_dir(input string name, input instr_t in, input logic [31:0] want, input int want_stalls);
        int st;
        issue(in, 0, 1'b0, 1'b0, st);
        chk({name, "_stall_cycles"}, 32'(st), 32'(want_stalls));
        idle();
        @(negedge clk);
        chk({name, "_result"}, alu_out_mem, want);
    endtask

    // Monitor: a valid MEM output is new only if the register loaded on the last edge.
    initial begin
        logic st, rs, fl;
        exp_t e;
        forever begin
            @(posedge clk);
            st = mem_stall; rs = rst; fl = flush;
            @(negedge clk);
            if (out_valid && !st && rs && !fl) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got 0x%08h, required no output", alu_out_mem);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_alu_out_mem", alu_out_mem, e.res);
                    chk("sb_rd_addr_mem", 32'(rd_addr_mem), 32'(e.rd));
                    chk("sb_wb_en_mem", 32'(wb_en_mem), 32'(e.wb));
                end
            end
        end
    end

    initial begin
        instr_t in;
        int     st;
        logic [4:0] rop;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_wb_en_mem", 32'(wb_en_mem), 0);
        chk("reset_rd_addr_mem", 32'(rd_addr_mem), 0);
        chk("reset_alu_out_mem", alu_out_mem, 0);
        chk("reset_ex_stall", 32'(ex_stall), 0);
        @(posedge clk); #1 rst = 1'b1;

        // ADD via forwarding slice 1 and immediate
        in = plain(5'd0, 32'd99, 32'h1234);
        in.fwd = {32'd5, 32'd77}; in.s1 = 2'd2; in.uimm = 1'b1; in.imm = 32'd7;
        issue(in, 0, 1'b0, 1'b0, st);
        chk("add_stall_cycles", 32'(st), 0);
        idle();
        @(negedge clk);
        chk("add_out_valid", 32'(out_valid), 1);
        chk("add_result", alu_out_mem, 32'd12);

        run_dir("sra",   plain(5'd7,  32'h80000000, 32'd4), 32'hF8000000, 0);
        run_dir("mulh",  plain(5'h11, 32'hFFFFFFFE, 32'd3), 32'hFFFFFFFF, 0);
        run_dir("mulhu", plain(5'h13, 32'hFFFFFFFF, 32'd2), 32'd1, 0);
        run_dir("div",   plain(5'h14, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD, 33);
        run_dir("rem",   plain(5'h16, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF, 33);
        run_dir("divu0", plain(5'h15, 32'd9, 32'd0), 32'hFFFFFFFF, 33);
        run_dir("remov", plain(5'h16, 32'h80000000, 32'hFFFFFFFF), 32'd0, 33);
        run_dir("divov", plain(5'h14, 32'h80000000, 32'hFFFFFFFF), 32'h80000000, 33);

        // Back-to-back divides, the first with operands scrambled during RUN
        issue(plain(5'h15, 32'd1000, 32'd7), 0, 1'b0, 1'b1, st);
        chk("b2b_first_stalls", 32'(st), 33);
        issue(plain(5'h17, 32'd1000, 32'd7), 0, 1'b0, 1'b0, st);
        chk("b2b_second_stalls", 32'(st), 33);

        // Back-pressure while DONE holds the result and ex_stall
        issue(plain(5'h14, 32'd100, 32'hFFFFFFFD), 3, 1'b0, 1'b0, st);
        chk("done_hold_stalls", 32'(st), 36);
        idle();
        @(negedge clk);
        chk("done_hold_result", alu_out_mem, 32'hFFFFFFDF);

        // Flush in cycle 10 of a divide
        @(posedge clk); #1;
        drive(plain(5'h14, 32'd100, 32'd7));
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ex_stall", 32'(ex_stall), 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_wb_en_mem", 32'(wb_en_mem), 0);
        run_dir("post_flush_add", plain(5'd0, 32'd40, 32'd2), 32'd42, 0);
        run_dir("post_flush_div", plain(5'h14, 32'd40, 32'd3), 32'd13, 33);

        // Reset in the middle of RUN while MEM holds a valid result
        issue(plain(5'd0, 32'd3, 32'd4), 0, 1'b0, 1'b0, st);
        @(posedge clk); #1;
        drive(plain(5'h14, 32'd50, 32'd5));
        mem_stall = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("stall_hold_valid", 32'(out_valid), 1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; mem_stall = 1'b0;
        @(negedge clk);
        chk("midrun_rst_out_valid", 32'(out_valid), 0);
        chk("midrun_rst_wb_en_mem", 32'(wb_en_mem), 0);
        chk("midrun_rst_rd_addr_mem", 32'(rd_addr_mem), 0);
        chk("midrun_rst_alu_out_mem", alu_out_mem, 0);
        run_dir("post_rst_div", plain(5'h16, 32'd50, 32'd7), 32'd1, 33);

        // Randomized mix with random back-pressure
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 23));
            if (r < 16) rop = {1'b0, 4'(r)};
            else        rop = {1'b1, 1'($urandom_range(0, 1)), 3'(r - 16)};
            in = plain(rop, 32'd0, 32'd0);
            for (int k = 0; k < 6; k++) begin
                logic [31:0] v;
                case ($urandom_range(0, 7))
                    0: v = 32'd0;
                    1: v = 32'h80000000;
                    2: v = 32'hFFFFFFFF;
                    3: v = 32'($urandom_range(0, 9));
                    default: v = $urandom;
                endcase
                case (k)
                    0: in.r1 = v;
                    1: in.r2 = v;
                    2: in.pc = v;
                    3: in.imm = v;
                    4: in.fwd[31:0] = v;
                    default: in.fwd[63:32] = v;
                endcase
            end
            in.s1 = 2'($urandom_range(0, 3)); in.s2 = 2'($urandom_range(0, 3));
            in.upc = ($urandom_range(0, 3) == 0); in.uimm = ($urandom_range(0, 3) == 0);
            in.wb = 1'($urandom_range(0, 1));
            issue(in, 0, 1'b1, rop[4] & rop[2], st);
            if ($urandom_range(0, 2) == 0) idle();
        end

        idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
